// File: rtl/fpu_mul_iter.sv
// fpu_mul_iter: iterative floating-point multiplier, RADIX multiplier bits per cycle,
// DAZ/FTZ, five rounding modes, valid/ready handshake with one operation in flight.
module fpu_mul_iter #(
   parameter int EXP_W = 11,
   parameter int MAN_W = 52,
   parameter int RADIX = 4,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_vld,
   output logic         in_rdy,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic [2:0]   rmode,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic [W-1:0] res,
   output logic [4:0]   raise
);
   localparam int M = MAN_W + 1;
   localparam int ITER = (M + RADIX - 1) / RADIX;
   localparam int CW = $clog2(ITER + 1);
   localparam int EW = EXP_W + 2;
   localparam int BIAS = (1 << (EXP_W - 1)) - 1;
   localparam logic [EXP_W-1:0] EMAX = '1;
   localparam logic [EXP_W-1:0] EFIN = EMAX - 1'b1;
   localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

   state_t              state_q;
   logic [2*M-1:0]      acc_q, ma_q;
   logic [ITER*RADIX-1:0] mb_q;
   logic [EW-1:0]       exp_q;
   logic [CW-1:0]       cnt_q;
   logic                sgn_q, daz_q, out_vld_q;
   logic [2:0]          rm_q;
   logic [W-1:0]        res_q;
   logic [4:0]          raise_q;

   logic                sa, sb, za, zb, ia, ib, na, nb, inv, special, daz;
   logic [EXP_W-1:0]    ea, eb;
   logic [MAN_W-1:0]    fa, fb;
   logic [W-1:0]        sp_res;

   assign {sa, ea, fa} = A;
   assign {sb, eb, fb} = B;
   assign za = ea == '0;
   assign zb = eb == '0;
   assign ia = ea == EMAX && fa == '0;
   assign ib = eb == EMAX && fb == '0;
   assign na = ea == EMAX && fa != '0;
   assign nb = eb == EMAX && fb != '0;
   assign daz = (za && fa != '0) || (zb && fb != '0);
   assign inv = (na && !fa[MAN_W-1]) || (nb && !fb[MAN_W-1]) || (ia && zb) || (ib && za);
   assign special = za || zb || ia || ib || na || nb;
   assign sp_res = (inv || na || nb) ? QNAN :
                   (ia || ib) ? {sa ^ sb, EMAX, {MAN_W{1'b0}}} : {sa ^ sb, {(W-1){1'b0}}};

   // Product lies in [1,4): pick the M-bit window, then guard and sticky below it.
   logic                hi, g, st, inc, ovf, unf, to_inf;
   logic [M-1:0]        man;
   logic [M:0]          man_r;
   logic [EW-1:0]       exp_f;
   logic [W-1:0]        n_res;

   assign hi = acc_q[2*M-1];
   assign man = hi ? acc_q[2*M-1 -: M] : acc_q[2*M-2 -: M];
   assign g = hi ? acc_q[M-1] : acc_q[M-2];
   assign st = hi ? |acc_q[M-2:0] : |acc_q[M-3:0];
   assign inc = rm_q == 3'd0 ? 1'b0 :
                rm_q == 3'd1 ? g :
                rm_q == 3'd3 ? ~sgn_q & (g | st) :
                rm_q == 3'd4 ? sgn_q & (g | st) : g & (st | man[0]);
   assign man_r = {1'b0, man} + (M+1)'(inc);
   assign exp_f = exp_q + EW'(hi) + EW'(man_r[M]);
   assign ovf = $signed(exp_f) >= $signed({2'b00, EMAX});
   assign unf = $signed(exp_f) <= $signed(EW'(0));
   assign to_inf = rm_q == 3'd0 ? 1'b0 : rm_q == 3'd3 ? ~sgn_q : rm_q == 3'd4 ? sgn_q : 1'b1;
   assign n_res = ovf ? (to_inf ? {sgn_q, EMAX, {MAN_W{1'b0}}} : {sgn_q, EFIN, {MAN_W{1'b1}}}) :
                  unf ? {sgn_q, {(W-1){1'b0}}} : {sgn_q, exp_f[EXP_W-1:0], man_r[M-2:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         out_vld_q <= 1'b0;
         res_q     <= '0;
         raise_q   <= '0;
         cnt_q     <= '0;
      end else begin
         case (state_q)
            IDLE: if (in_vld) begin
               sgn_q <= sa ^ sb;
               rm_q  <= rmode;
               daz_q <= daz;
               acc_q <= '0;
               cnt_q <= '0;
               ma_q  <= (2*M)'({1'b1, fa});
               mb_q  <= (ITER*RADIX)'({1'b1, fb});
               exp_q <= EW'(ea) + EW'(eb) - EW'(BIAS);
               if (special) begin
                  res_q     <= sp_res;
                  raise_q   <= {daz, 3'b000, inv};
                  out_vld_q <= 1'b1;
                  state_q   <= DONE;
               end else state_q <= MUL;
            end
            MUL: begin
               acc_q <= acc_q + ma_q * (2*M)'(mb_q[RADIX-1:0]);
               ma_q  <= ma_q << RADIX;
               mb_q  <= mb_q >> RADIX;
               if (cnt_q == CW'(ITER - 1)) state_q <= NORM;
               else cnt_q <= cnt_q + 1'b1;
            end
            NORM: begin
               res_q     <= n_res;
               raise_q   <= {daz_q, g | st | ovf | unf, unf, ovf, 1'b0};
               out_vld_q <= 1'b1;
               state_q   <= DONE;
            end
            DONE: if (out_rdy) begin
               out_vld_q <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_rdy = state_q == IDLE;
   assign out_vld = out_vld_q;
   assign res = res_q;
   assign raise = raise_q;
endmodule

// File: tb/tb_fpu_mul_iter.sv
// tb_fpu_mul_iter: directed and randomized checks of fpu_mul_iter in double and single
// formats against an exact-product reference model.
module tb_fpu_mul_iter;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   logic iv64, ir64, ov64, or64, iv32, ir32, ov32, or32;
   logic [63:0] a64, b64, r64;
   logic [31:0] a32, b32, r32;
   logic [2:0]  m64, m32;
   logic [4:0]  f64, f32;

   fpu_mul_iter dut64 (
      .clk(clk), .rst(rst), .in_vld(iv64), .in_rdy(ir64), .A(a64), .B(b64), .rmode(m64),
      .out_vld(ov64), .out_rdy(or64), .res(r64), .raise(f64)
   );
   fpu_mul_iter #(.EXP_W(8), .MAN_W(23), .RADIX(8)) dut32 (
      .clk(clk), .rst(rst), .in_vld(iv32), .in_rdy(ir32), .A(a32), .B(b32), .rmode(m32),
      .out_vld(ov32), .out_rdy(or32), .res(r32), .raise(f32)
   );

   int total = 0, passed = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Exact product, then rounding decided by comparing the discarded remainder to half an ulp.
   function automatic void model(input int ew, input int mw, input int radix,
                                 input logic [63:0] a, input logic [63:0] b, input logic [2:0] rm,
                                 output logic [63:0] r, output logic [4:0] f, output int lat);
      int m, emax, bias, ea, eb, e, sh;
      logic [63:0] fa, fb, mask, sgn, qnan;
      logic [127:0] p, q, rem, half;
      logic s, za, zb, ia, ib, na, nb, sn, inc, toinf;
      m = mw + 1;
      emax = (1 << ew) - 1;
      bias = (1 << (ew - 1)) - 1;
      mask = (64'd1 << mw) - 1;
      ea = int'((a >> mw) & 64'(emax));
      eb = int'((b >> mw) & 64'(emax));
      fa = a & mask;
      fb = b & mask;
      s = a[ew+mw] ^ b[ew+mw];
      sgn = 64'(s) << (ew + mw);
      qnan = (64'(emax) << mw) | (64'd1 << (mw - 1));
      za = ea == 0;
      zb = eb == 0;
      ia = ea == emax && fa == 0;
      ib = eb == emax && fb == 0;
      na = ea == emax && fa != 0;
      nb = eb == emax && fb != 0;
      sn = (na && !fa[mw-1]) || (nb && !fb[mw-1]);
      f = {(za && fa != 0) || (zb && fb != 0), 4'b0000};
      lat = 1;
      if (sn || (ia && zb) || (ib && za)) begin
         r = qnan;
         f[0] = 1'b1;
      end else if (na || nb) r = qnan;
      else if (ia || ib) r = sgn | (64'(emax) << mw);
      else if (za || zb) r = sgn;
      else begin
         lat = (m + radix - 1) / radix + 2;
         p = 128'(fa | (64'd1 << mw)) * 128'(fb | (64'd1 << mw));
         sh = p[2*m-1] ? m : m - 1;
         e = ea + eb - bias + (sh == m ? 1 : 0);
         q = p >> sh;
         rem = p - (q << sh);
         half = 128'd1 << (sh - 1);
         case (rm)
            3'd0: inc = 1'b0;
            3'd1: inc = rem >= half;
            3'd3: inc = !s && rem != 0;
            3'd4: inc = s && rem != 0;
            default: inc = rem > half || (rem == half && q[0]);
         endcase
         q = q + 128'(inc);
         if (q == (128'd1 << m)) begin
            q = q >> 1;
            e++;
         end
         if (e >= emax) begin
            toinf = rm == 1 || rm == 2 || rm >= 5 || (rm == 3 && !s) || (rm == 4 && s);
            r = sgn | (toinf ? 64'(emax) << mw : (64'(emax - 1) << mw) | mask);
            f[1] = 1'b1;
            f[3] = 1'b1;
         end else if (e <= 0) begin
            r = sgn;
            f[2] = 1'b1;
            f[3] = 1'b1;
         end else begin
            r = sgn | (64'(e) << mw) | (q[63:0] & mask);
            f[3] = rem != 0;
         end
      end
   endfunction

   function automatic logic [63:0] rnd_op(input int ew, input int mw);
      int emax, bias, e;
      logic [63:0] mask, fr;
      logic s;
      emax = (1 << ew) - 1;
      bias = (1 << (ew - 1)) - 1;
      mask = (64'd1 << mw) - 1;
      fr = {$urandom, $urandom} & mask;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 15))
         0: begin e = 0; fr = 0; end
         1: e = 0;
         2: begin e = emax; fr = 0; end
         3: begin e = emax; fr = fr | (64'd1 << (mw - 1)); end
         4: begin e = emax; fr = (fr & (mask >> 1)) | 64'd1; end
         5: e = emax - 1 - int'($urandom_range(0, 3));
         6: e = 1 + int'($urandom_range(0, 3));
         default: e = bias - 20 + int'($urandom_range(0, 40));
      endcase
      return (64'(s) << (ew + mw)) | (64'(e) << mw) | fr;
   endfunction

   // Latency counts posedges from the accept edge to the first edge showing out_vld.
   task automatic op(input bit w, input logic [63:0] a, input logic [63:0] b, input logic [2:0] rm,
                     output logic [63:0] r, output logic [4:0] f, output int lat);
      @(negedge clk);
      check("in_rdy_idle", 64'(w ? ir64 : ir32), 64'd1);
      if (w) begin a64 = a; b64 = b; m64 = rm; iv64 = 1'b1; end
      else begin a32 = a[31:0]; b32 = b[31:0]; m32 = rm; iv32 = 1'b1; end
      @(negedge clk);
      iv64 = 1'b0;
      iv32 = 1'b0;
      lat = 1;
      while (!(w ? ov64 : ov32) && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      r = w ? r64 : 64'(r32);
      f = w ? f64 : f32;
   endtask

   task automatic dir(input string tag, input bit w, input logic [63:0] a, input logic [63:0] b,
                      input logic [2:0] rm, input logic [63:0] er, input logic [4:0] ef, input int el);
      logic [63:0] r;
      logic [4:0] f;
      int lat;
      op(w, a, b, rm, r, f, lat);
      check({tag, ".res"}, r, er);
      check({tag, ".raise"}, 64'(f), 64'(ef));
      check({tag, ".lat"}, 64'(lat), 64'(el));
   endtask

   task automatic rnd(input string tag, input bit w);
      logic [63:0] a, b, er;
      logic [4:0] ef;
      logic [2:0] rm;
      int el;
      a = rnd_op(w ? 11 : 8, w ? 52 : 23);
      b = rnd_op(w ? 11 : 8, w ? 52 : 23);
      rm = 3'($urandom_range(0, 7));
      model(w ? 11 : 8, w ? 52 : 23, w ? 4 : 8, a, b, rm, er, ef, el);
      dir(tag, w, a, b, rm, er, ef, el);
   endtask

   initial begin
      logic seen;
      int n;
      iv64 = 0; iv32 = 0; or64 = 1; or32 = 1;
      a64 = 0; b64 = 0; m64 = 0; a32 = 0; b32 = 0; m32 = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst.out_vld64", 64'(ov64), 64'd0);
      check("rst.res64", r64, 64'd0);
      check("rst.raise64", 64'(f64), 64'd0);
      check("rst.in_rdy64", 64'(ir64), 64'd1);
      check("rst.out_vld32", 64'(ov32), 64'd0);
      check("rst.res32", 64'(r32), 64'd0);

      dir("mul1p5x2", 1, 64'h3FF8000000000000, 64'h4000000000000000, 3'd2, 64'h4008000000000000, 5'h00, 16);
      dir("infx0", 1, 64'h7FF0000000000000, 64'h0000000000000000, 3'd2, 64'h7FF8000000000000, 5'h01, 1);
      dir("ovf_rne", 1, 64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 3'd2, 64'h7FF0000000000000, 5'h0A, 16);
      dir("ovf_trunc", 1, 64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 3'd0, 64'h7FEFFFFFFFFFFFFF, 5'h0A, 16);
      dir("ovf_neg_up", 1, 64'hFFEFFFFFFFFFFFFF, 64'h4000000000000000, 3'd3, 64'hFFEFFFFFFFFFFFFF, 5'h0A, 16);
      dir("ftz", 1, 64'h8010000000000000, 64'h3FE0000000000000, 3'd2, 64'h8000000000000000, 5'h0C, 16);
      dir("daz", 1, 64'h0000000000000001, 64'h3FF0000000000000, 3'd2, 64'h0000000000000000, 5'h10, 1);
      dir("snan", 1, 64'h7FF0000000000001, 64'h3FF0000000000000, 3'd2, 64'h7FF8000000000000, 5'h01, 1);
      dir("qnan", 1, 64'h7FF8000000000000, 64'h3FF0000000000000, 3'd2, 64'h7FF8000000000000, 5'h00, 1);
      dir("ninfx2", 1, 64'hFFF0000000000000, 64'h4000000000000000, 3'd2, 64'hFFF0000000000000, 5'h00, 1);
      dir("sp_rne", 0, 64'h3F800001, 64'h3F800001, 3'd2, 64'h3F800002, 5'h08, 5);
      dir("sp_up", 0, 64'h3F800001, 64'h3F800001, 3'd3, 64'h3F800003, 5'h08, 5);
      dir("sp_down", 0, 64'hBF800001, 64'h3F800001, 3'd4, 64'hBF800003, 5'h08, 5);

      // DONE holds under backpressure and ignores in_vld.
      @(negedge clk);
      or64 = 1'b0;
      a64 = 64'h3FF8000000000000; b64 = 64'h4000000000000000; m64 = 3'd2; iv64 = 1'b1;
      @(negedge clk);
      iv64 = 1'b0;
      n = 1;
      while (!ov64 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("hold.lat", 64'(n), 64'd16);
      for (int k = 0; k < 5; k++) begin
         iv64 = 1'b1;
         a64 = {$urandom, $urandom};
         @(negedge clk);
         check("hold.res", r64, 64'h4008000000000000);
         check("hold.in_rdy", 64'(ir64), 64'd0);
         check("hold.out_vld", 64'(ov64), 64'd1);
      end
      check("hold.raise", 64'(f64), 64'd0);
      iv64 = 1'b0;
      or64 = 1'b1;
      @(negedge clk);
      check("release.out_vld", 64'(ov64), 64'd0);
      check("release.in_rdy", 64'(ir64), 64'd1);

      // Reset while multiplying aborts the operation.
      a64 = 64'h3FF8000000000000; b64 = 64'h4000000000000000; iv64 = 1'b1;
      @(negedge clk);
      iv64 = 1'b0;
      repeat (4) @(negedge clk);
      check("mul.in_rdy", 64'(ir64), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort.in_rdy", 64'(ir64), 64'd1);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen = seen | ov64;
      end
      check("abort.no_out", 64'(seen), 64'd0);

      for (int i = 0; i < 40; i++) rnd("rnd64", 1);
      for (int i = 0; i < 25; i++) rnd("rnd32", 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
